cache_mem_arbiter: RTL

//  Shares the single 256-bit physical-memory line port (the burst memory model behind the

---
 rtl/arb_pkg.sv | 14 +
 rtl/cache_mem_arbiter_if.sv | 39 +++
 rtl/cache_mem_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and widths for the I/D cache to physical-memory line arbiter.
package arb_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;

  // Clears the byte-within-line offset so pmem always sees line-aligned addresses
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} arb_grant_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side line bus seen by the arbiter.
interface cache_mem_arbiter_if import arb_pkg::*; ();

  logic              icache_read;
  logic [ADDR_W-1:0] icache_addr;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_addr;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // Arbiter side
  modport slave (
    input  icache_read, icache_addr, dcache_read, dcache_write, dcache_addr, dcache_wdata,
    input  pmem_rdata, pmem_resp,
    output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  // Caches plus memory model side
  modport master (
    output icache_read, icache_addr, dcache_read, dcache_write, dcache_addr, dcache_wdata,
    output pmem_rdata, pmem_resp,
    input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide physical-memory port between I-cache and D-cache.
// One transaction in flight; pmem_* are registered, responses are steered combinationally.
module cache_mem_arbiter
  import arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  cache_mem_arbiter_if.slave  bus
);

  arb_state_t state_q, state_d;
  arb_grant_t last_grant_q, last_grant_d;

  logic              take_i, take_d, d_req;
  logic              icache_resp_c, dcache_resp_c;
  logic              pmem_read_q, pmem_write_q;
  logic [ADDR_W-1:0] pmem_address_q;
  logic [LINE_W-1:0] pmem_wdata_q;

  assign d_req = bus.dcache_read | bus.dcache_write;

  // Next state, grant decision and response steering
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    take_i        = 1'b0;
    take_d        = 1'b0;
    icache_resp_c = 1'b0;
    dcache_resp_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.icache_read && d_req) begin
          take_d = (last_grant_q == GRANT_I);
          take_i = (last_grant_q == GRANT_D);
        end else begin
          take_i = bus.icache_read;
          take_d = d_req;
        end
        if (take_i) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
        end else if (take_d) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
        end
      end
      SERVE_I: begin
        if (bus.pmem_resp) begin
          icache_resp_c = 1'b1;
          state_d       = DONE;
        end
      end
      SERVE_D: begin
        if (bus.pmem_resp) begin
          dcache_resp_c = 1'b1;
          state_d       = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Request latch: captured on grant, held untouched until the memory completes
  always_ff @(posedge clk) begin
    if (rst) begin
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else if (take_i) begin
      pmem_read_q    <= 1'b1;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= bus.icache_addr & LINE_MASK;
    end else if (take_d) begin
      // A simultaneous read+write is illegal; the write wins
      pmem_read_q    <= ~bus.dcache_write;
      pmem_write_q   <= bus.dcache_write;
      pmem_address_q <= bus.dcache_addr & LINE_MASK;
      pmem_wdata_q   <= bus.dcache_wdata;
    end else if (icache_resp_c || dcache_resp_c) begin
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(bus.dcache_read && bus.dcache_write));

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;
  assign bus.icache_resp  = icache_resp_c;
  assign bus.dcache_resp  = dcache_resp_c;
  // Both requesters see the returned line; only the resp pulse qualifies it
  assign bus.icache_rdata = bus.pmem_rdata;
  assign bus.dcache_rdata = bus.pmem_rdata;

endmodule
